// File: rtl/dccm_arbiter_if.sv
// dccm_arbiter_if: one requester's DCCM request/grant/response channel
interface dccm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  modport master(output req, we, addr, wdata, lock, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, wdata, lock, output gnt, rvalid, rdata);
endinterface

// File: rtl/dccm_arbiter.sv
// dccm_arbiter: shares one DCCM port between LSU and DBG with starvation guard, debug lock and read-response routing
module dccm_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  dccm_arbiter_if.slave     i_lsu,
  dccm_arbiter_if.slave     i_dbg,
  output logic              o_dccm_wr_en,
  output logic              o_dccm_rd_en,
  output logic [ADDR_W-1:0] o_dccm_wr_addr,
  output logic [ADDR_W-1:0] o_dccm_rd_addr,
  output logic [DATA_W-1:0] o_dccm_wr_data,
  input  logic [DATA_W-1:0] i_dccm_rd_data
);
  typedef enum logic {ARB, DBG_LOCK} state_t;
  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);
  state_t            r_state;
  logic [3:0]        r_starve;
  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_id;
  logic              w_arb;
  logic              w_dbg_win;
  logic              w_lsu_gnt;
  logic              w_dbg_gnt;
  logic              w_we;
  logic              w_out_v;
  logic [ADDR_W-1:0] w_addr;
  always_comb begin
    w_arb     = r_state == ARB || !i_dbg.lock;
    w_dbg_win = i_dbg.req && (!w_arb || !i_lsu.req || r_starve == STARVE_MAX);
    w_dbg_gnt = !rst && w_dbg_win;
    w_lsu_gnt = !rst && w_arb && i_lsu.req && !w_dbg_win;
    w_we      = w_dbg_gnt ? i_dbg.we : i_lsu.we;
    w_addr    = w_dbg_gnt ? i_dbg.addr : w_lsu_gnt ? i_lsu.addr : '0;
    w_out_v   = !rst && r_vld[RD_LAT-1];
  end
  assign i_lsu.gnt      = w_lsu_gnt;
  assign i_dbg.gnt      = w_dbg_gnt;
  assign o_dccm_wr_en   = (w_lsu_gnt || w_dbg_gnt) && w_we;
  assign o_dccm_rd_en   = (w_lsu_gnt || w_dbg_gnt) && !w_we;
  assign o_dccm_wr_addr = o_dccm_wr_en ? w_addr : '0;
  assign o_dccm_rd_addr = o_dccm_rd_en ? w_addr : '0;
  assign o_dccm_wr_data = !o_dccm_wr_en ? '0 : w_dbg_gnt ? i_dbg.wdata : i_lsu.wdata;
  assign i_lsu.rvalid   = w_out_v && !r_id[RD_LAT-1];
  assign i_dbg.rvalid   = w_out_v && r_id[RD_LAT-1];
  assign i_lsu.rdata    = i_lsu.rvalid ? i_dccm_rd_data : '0;
  assign i_dbg.rdata    = i_dbg.rvalid ? i_dccm_rd_data : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ARB;
      r_starve <= '0;
      r_vld    <= '0;
      r_id     <= '0;
    end else begin
      r_state  <= (w_dbg_gnt && i_dbg.lock) ? DBG_LOCK : i_dbg.lock ? r_state : ARB;
      r_starve <= (i_dbg.req && !w_dbg_gnt) ? r_starve + {3'b0, r_starve != STARVE_MAX} : '0;
      r_vld[0] <= o_dccm_rd_en;
      r_id[0]  <= w_dbg_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end
endmodule
